// File: rtl/mux_pkg.sv
// Shared types and helpers for the arbitrated N:1 mux and its arbiter.
package mux_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter with round-robin or fixed priority; owns the rotation pointer.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int        N    = 4,
  parameter arb_mode_e MODE = ARB_RR,
  localparam int       SELW = sel_width(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  localparam logic [SELW-1:0] IDX_ONE  = SELW'(1);
  localparam logic [SELW-1:0] IDX_LAST = SELW'(N - 1);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] start;
  logic            found;
  logic            hit;
  int              cand;

  assign start = (MODE == ARB_RR) ? ptr : {SELW{1'b0}};

  // Scan start, start+1, ... with wrap; the first requester found wins.
  always_comb begin
    grant     = {N{1'b0}};
    grant_idx = {SELW{1'b0}};
    found     = 1'b0;
    hit       = 1'b0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand       = int'(start) + k;
      cand       = (cand >= N) ? cand - N : cand;
      hit        = !found && req[cand];
      grant[cand] = hit;
      grant_idx  = hit ? cand[SELW-1:0] : grant_idx;
      found      = found || hit;
    end
  end

  // Pointer moves just past the winner on every accepted transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= {SELW{1'b0}};
    end else if ((MODE == ARB_RR) && advance) begin
      ptr <= (grant_idx == IDX_LAST) ? {SELW{1'b0}} : grant_idx + IDX_ONE;
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/rr_mux_arb.sv
// Arbitrated N:1 mux with valid/ready inputs and a registered valid/ready output stage.
module rr_mux_arb
  import mux_pkg::*;
#(
  parameter int        WIDTH = 8,
  parameter int        N     = 4,
  parameter arb_mode_e MODE  = ARB_RR,
  localparam int       SELW  = sel_width(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  logic             load;
  logic             take;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] sel_data;

  // The register can accept a new word whenever it is empty or being drained.
  assign load     = !out_valid || out_ready;
  assign take     = load && !reset && (|grant);
  assign in_ready = (load && !reset) ? grant : {N{1'b0}};

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_valid),
    .advance   (take),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // AND-OR data mux driven by the one-hot grant.
  always_comb begin
    sel_data = {WIDTH{1'b0}};
    for (int i = 0; i < N; i++) begin
      sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  // Output register: load on transfer, empty when loadable with nothing granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
      out_sel   <= {SELW{1'b0}};
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant_idx;
    end else if (load) begin
      out_valid <= 1'b0;
      out_data  <= out_data;
      out_sel   <= out_sel;
    end else begin
      out_valid <= out_valid;
      out_data  <= out_data;
      out_sel   <= out_sel;
    end
  end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: RR N=4, RR N=3 and fixed-priority N=4 instances.
module tb_rr_mux_arb;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic [3:0]  v4, rdy4;
  logic [31:0] d4;
  logic        ov4, ordy4;
  logic [7:0]  od4;
  logic [1:0]  os4;

  logic [2:0]  v3, rdy3;
  logic [23:0] d3;
  logic        ov3, ordy3;
  logic [7:0]  od3;
  logic [1:0]  os3;

  logic [3:0]  vf, rdyf;
  logic [31:0] df;
  logic        ovf, ordyf;
  logic [7:0]  odf;
  logic [1:0]  osf;

  rr_mux_arb #(.WIDTH(8), .N(4), .MODE(ARB_RR)) u_rr4 (
    .clk(clk), .reset(reset), .in_valid(v4), .in_data(d4), .in_ready(rdy4),
    .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(ordy4));

  rr_mux_arb #(.WIDTH(8), .N(3), .MODE(ARB_RR)) u_rr3 (
    .clk(clk), .reset(reset), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
    .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(ordy3));

  rr_mux_arb #(.WIDTH(8), .N(4), .MODE(ARB_FIXED)) u_fx4 (
    .clk(clk), .reset(reset), .in_valid(vf), .in_data(df), .in_ready(rdyf),
    .out_valid(ovf), .out_data(odf), .out_sel(osf), .out_ready(ordyf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    v4 = 4'hF; d4 = {8'h13, 8'h12, 8'h11, 8'h10}; ordy4 = 1'b1;
    v3 = 3'b000; d3 = {8'h32, 8'h31, 8'h30}; ordy3 = 1'b1;
    vf = 4'h0; df = {8'hF3, 8'hF2, 8'hF1, 8'hF0}; ordyf = 1'b1;

    // Reset held for two cycles with every channel valid
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_in_ready", 32'(rdy4), 32'h0);
      chk("rst_out_valid", 32'(ov4), 32'h0);
      chk("rst_out_data", 32'(od4), 32'h0);
      chk("rst_out_sel", 32'(os4), 32'h0);
    end
    reset = 1'b0;
    #1;
    chk("first_grant_ch0", 32'(rdy4), 32'h1);

    // Round-robin rotation, all channels valid
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_out_valid", 32'(ov4), 32'h1);
      chk("rr_out_sel", 32'(os4), 32'(k % 4));
      chk("rr_out_data", 32'(od4), 32'h10 + 32'(k % 4));
    end
    chk("rr_ptr_wrapped", 32'(u_rr4.u_arb.ptr), 32'h0);

    // Single channel 2 with data A5
    v4 = 4'b0100; d4 = {8'h13, 8'hA5, 8'h11, 8'h10};
    #1;
    chk("single_in_ready", 32'(rdy4), 32'h4);
    tick();
    chk("single_out_valid", 32'(ov4), 32'h1);
    chk("single_out_data", 32'(od4), 32'hA5);
    chk("single_out_sel", 32'(os4), 32'h2);

    // Load 11 from channel 1 (ptr 3 wraps past channel 0), then stall
    v4 = 4'b0010; d4 = {8'h13, 8'h12, 8'h11, 8'h10};
    tick();
    chk("bp_load_data", 32'(od4), 32'h11);
    chk("bp_load_sel", 32'(os4), 32'h1);
    ordy4 = 1'b0; v4 = 4'hF;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_in_ready", 32'(rdy4), 32'h0);
      tick();
      chk("bp_hold_valid", 32'(ov4), 32'h1);
      chk("bp_hold_data", 32'(od4), 32'h11);
      chk("bp_ptr_hold", 32'(u_rr4.u_arb.ptr), 32'h2);
    end
    ordy4 = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(rdy4), 32'h4);
    tick();
    chk("bp_resume_sel", 32'(os4), 32'h2);
    chk("bp_resume_data", 32'(od4), 32'h12);

    // No valid input while loadable empties the register, data/sel hold
    v4 = 4'h0;
    tick();
    chk("clear_valid", 32'(ov4), 32'h0);
    chk("clear_data_hold", 32'(od4), 32'h12);
    chk("clear_sel_hold", 32'(os4), 32'h2);

    // N=3 wrap/skip: move ptr to 2 via channel 1, then ch0/ch1 valid
    v3 = 3'b010;
    tick();
    chk("n3_setup_sel", 32'(os3), 32'h1);
    chk("n3_ptr2", 32'(u_rr3.u_arb.ptr), 32'h2);
    v3 = 3'b011;
    #1;
    chk("n3_wrap_ready", 32'(rdy3), 32'h1);
    tick();
    chk("n3_wrap_sel", 32'(os3), 32'h0);
    chk("n3_wrap_data", 32'(od3), 32'h30);
    chk("n3_ptr1", 32'(u_rr3.u_arb.ptr), 32'h1);
    #1;
    chk("n3_next_ready", 32'(rdy3), 32'h2);
    tick();
    chk("n3_next_sel", 32'(os3), 32'h1);
    chk("n3_next_data", 32'(od3), 32'h31);
    v3 = 3'b000;

    // Fixed priority: ch1 always beats ch3
    vf = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("fx_in_ready", 32'(rdyf), 32'h2);
      tick();
      chk("fx_out_valid", 32'(ovf), 32'h1);
      chk("fx_out_sel", 32'(osf), 32'h1);
      chk("fx_out_data", 32'(odf), 32'hF1);
      chk("fx_ptr_zero", 32'(u_fx4.u_arb.ptr), 32'h0);
    end

    // Mid-stream reset drops the held word and masks in_ready
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(rdyf), 32'h0);
    tick();
    chk("midrst_out_valid", 32'(ovf), 32'h0);
    chk("midrst_out_data", 32'(odf), 32'h0);
    reset = 1'b0;
    #1;
    chk("postrst_in_ready", 32'(rdyf), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised successor to the fixed 4:1 8-bit mux.
- Selects one of N input channels by arbitration, not an external select.
- Inputs use valid/ready handshakes; output is a registered valid/ready stage.
- Sits between multiple producers and a single shared consumer, e.g. a shared bus or write port.

Parameters:
- WIDTH, 8: data width of every channel and of the output.
- N, 4: number of input channels, N >= 1; N need not be a power of two.
- MODE, ARB_RR: arbitration mode. ARB_RR is round-robin; ARB_FIXED is fixed priority with channel 0 highest.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  N  per-channel valid.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  N  per-channel ready; one-hot or zero.
- out_valid  out  1  output register holds a word.
- out_data  out  WIDTH  registered data.
- out_sel  out  SELW  index of the channel that supplied out_data. SELW = max(1, $clog2(N)).
- out_ready  in  1  consumer accepts the word.

Behaviour:
- Reset: out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0. All state is synchronous to clk.
- Load enable: load = !out_valid || out_ready (combinational).
- Grant, combinational:
  - ARB_RR: first i with in_valid[i]=1, scanning ptr, ptr+1, … N-1, 0, … ptr-1.
  - ARB_FIXED: lowest i with in_valid[i]=1.
  - No valid input: no grant.
- in_ready[i] = load && grant[i]. Never more than one bit set. in_ready may depend combinationally on out_ready; no dependence on in_data.
- Transfer on channel i occurs when in_valid[i] && in_ready[i]. At that edge: out_data <= channel i data, out_sel <= i, out_valid <= 1.
- Output clear: if load && no grant, out_valid <= 0. out_data and out_sel hold their last values.
- Output stall: if out_valid && !out_ready, the output register holds, all in_ready=0, and ptr holds.
- Latency: exactly 1 cycle from accepted input to out_valid.
- Throughput: 1 word/cycle sustained. A drain (out_ready=1) and a new load in the same cycle produce back-to-back words with no bubble.
- Pointer update (ARB_RR only): on a transfer from channel i, ptr <= (i == N-1) ? 0 : i+1. No transfer means ptr unchanged.
- In ARB_FIXED, ptr stays 0.
- Fairness (ARB_RR): with all N channels continuously valid and out_ready=1, grants rotate 0,1,…,N-1,0.
  - Any continuously-valid channel is granted within N transfers.
- Producer protocol: a producer must hold in_valid and in_data stable until accepted. The block does not check this.
- Reset mid-operation: the held output word is discarded (out_valid=0) and ptr returns to 0. No in_ready is asserted in a reset cycle.
- N=1: degenerates to a single register slice; out_sel is constant 0.

Decomposition:
- Package mux_pkg:
  - typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e.
  - Function sel_width(n) returning max(1, $clog2(n)).
- Sub-module rr_arbiter #(N, MODE):
  - Inputs: clk, reset, req[N], advance.
  - Outputs: grant[N] one-hot, grant_idx[SELW].
  - Owns ptr.
  - Top level instantiates it and supplies the data mux, output register and handshake.

Test Plan:
- Reset: assert reset 2 cycles with all in_valid=1. Required: in_ready=0, out_valid=0, out_data=0, out_sel=0. After release, first grant is channel 0.
- Single channel, WIDTH=8, N=4: in_valid=4'b0100, data2=8'hA5, out_ready=1. Required: in_ready=4'b0100 in the same cycle; next cycle out_valid=1, out_data=8'hA5, out_sel=2.
- RR rotation: all valid, data i = 8'h10+i, out_ready=1 for 8 cycles. Required: out_sel sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle after the first.
- Backpressure: out_valid=1 with out_data=8'h11, out_ready=0 for 3 cycles. Required: out_data holds 8'h11, in_ready=0, ptr unchanged. Raising out_ready resumes at the next channel (2).
- Wrap/skip, N=3: ptr=2, only ch0 and ch1 valid. Required: grant ch0, then ptr=1, then grant ch1.
- ARB_FIXED: ch1 and ch3 continuously valid. Required: ch1 always wins and ch3 starves. Mid-stream reset clears out_valid on the next edge.
